// File: rtl/booth_pkg.sv
// Shared types and elaboration helpers for the Booth multiplier sequencer.
package booth_pkg;

  // Default operand width of the multiplier datapath.
  localparam int N_DEFAULT = 4;

  // Sequencer states: idle/accepting, core load, core run, result hold.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Run cycles the shift-add core needs after load release.
  function automatic int lat_for(input int n);
    return n + 32'sd1;
  endfunction

  // Width of the run counter able to hold values up to lat.
  function automatic int cnt_width(input int lat);
    return $clog2(lat + 32'sd1);
  endfunction

endpackage

// File: rtl/booth_seq_ctrl.sv
// Sequencer wrapping a handshake-less shift-add Booth multiplier core:
// accepts an operand pair, holds the core in load, releases it for exactly
// LAT cycles, captures the product and presents it with full backpressure.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int LAT = lat_for(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [N-1:0]     op_mr,
  input  logic [N-1:0]     op_md,
  output logic             mul_load,
  output logic [N-1:0]     mul_mr,
  output logic [N-1:0]     mul_md,
  input  logic [2*N-1:0]   mul_prod,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2*N-1:0]   res_data,
  output logic             busy
);

  localparam int CW = cnt_width(LAT);
  // The run exit compares against LAT-1 only, so the counter never needs
  // saturation logic: it is cleared outside RUN.
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  if (N < 2) begin : g_n_check
    $error("booth_seq_ctrl: N must be at least 2");
  end
  if (LAT < 1) begin : g_lat_check
    $error("booth_seq_ctrl: LAT must be at least 1");
  end

  state_t            state_r;
  state_t            state_next_s;
  logic [CW-1:0]     cnt_r;
  logic [N-1:0]      mr_r;
  logic [N-1:0]      md_r;
  logic [2*N-1:0]    res_data_r;
  logic              accept_s;
  logic              capture_s;

  // Next-state decode plus the accept and capture strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (op_valid) begin
          state_next_s = LOAD;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        state_next_s = RUN;
      end
      RUN: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = HOLD;
          capture_s    = 1'b1;
        end else begin
          state_next_s = RUN;
        end
      end
      HOLD: begin
        if (res_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Run-cycle counter: counts only while the core is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (state_r == RUN) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  // Operand latches: written only on the acceptance edge so the core
  // inputs stay stable through LOAD, RUN and HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mr_r <= '0;
      md_r <= '0;
    end else if (accept_s) begin
      mr_r <= op_mr;
      md_r <= op_md;
    end else begin
      mr_r <= mr_r;
      md_r <= md_r;
    end
  end

  // Result register: samples the core product on the last run cycle and
  // stays frozen until the next capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_data_r <= '0;
    end else if (capture_s) begin
      res_data_r <= mul_prod;
    end else begin
      res_data_r <= res_data_r;
    end
  end

  // Outputs are the latches above or decodes of the registered state.
  assign mul_mr    = mr_r;
  assign mul_md    = md_r;
  assign res_data  = res_data_r;
  assign op_ready  = (state_r == IDLE);
  assign mul_load  = (state_r != RUN);
  assign res_valid = (state_r == HOLD);
  assign busy      = (state_r != IDLE);

endmodule
